core_switch_ctrl: RTL and testbench
===================================

Name: core_switch_ctrl

Overview:
- Consumes the two alive indicators produced by the per-core heartbeat detectors, one for core A and one for core B.
- Decides which core drives the shared outputs, with a qualified holdoff before any changeover and optional revert to A.
- Its output sel_b steers the downstream output multiplexers; switch_pulse and the fault flags go to the status/UART logic.

Parameters:
- HOLD_CYCLES, 14746, cycles the takeover condition must persist before switching (1 ms at 14.7456 MHz); legal range 1..65535.
- REVERTIVE, 0, when 1 the block returns to core A once A is healthy again; when 0 there is no automatic return.

Ports:
- clk  input  1  system clock, 14.7456 MHz.
- rst  input  1  asynchronous, active-high reset.
- alive_a  input  1  core A healthy; synchronous to clk.
- alive_b  input  1  core B healthy; synchronous to clk.
- sel_b  output  1  0 = core A active, 1 = core B active.
- switch_pulse  output  1  one-cycle strobe on every sel_b change.
- fault_a  output  1  registered copy of ~alive_a.
- fault_b  output  1  registered copy of ~alive_b.
- no_core  output  1  high while in S_NONE.
- state  output  3  current state encoding, for debug.

Behaviour:
- Reset is asynchronous, active-high, on clk domain. Reset values:
  - state = S_A, sel_b = 0, switch_pulse = 0, fault_a = 0, fault_b = 0, no_core = 0, hold counter = 0.
- States (3-bit): S_A = 0, S_B = 1, S_HOLD_B = 2, S_HOLD_A = 3, S_NONE = 4. Codes 5..7 go to S_A on the next clk.
- S_A:
  - alive_a = 1: stay.
  - alive_a = 0 and alive_b = 1: go to S_HOLD_B, counter cleared to 0.
  - alive_a = 0 and alive_b = 0: go to S_NONE.
- S_B (mirror of S_A):
  - alive_b = 0 and alive_a = 1: go to S_HOLD_A.
  - alive_b = 0 and alive_a = 0: go to S_NONE.
  - REVERTIVE = 1 and alive_a = 1 and alive_b = 1: go to S_HOLD_A.
- S_HOLD_B:
  - Abort to S_A when alive_a = 1 or alive_b = 0, evaluated every cycle. Abort takes priority over completion.
  - Otherwise the counter increments. When counter == HOLD_CYCLES-1, go to S_B.
  - sel_b = 1 and switch_pulse = 1 in the same first cycle of S_B.
  - Switch latency is exactly HOLD_CYCLES cycles after entering the hold state.
- S_HOLD_A: mirror of S_HOLD_B.
  - Non-revertive: abort to S_B when alive_b = 1 or alive_a = 0.
  - Revertive (entered with B healthy): abort to S_B only when alive_a = 0.
- S_NONE:
  - sel_b holds its last value and no_core = 1.
  - The currently selected core becomes alive: return directly to S_A or S_B, no holdoff.
  - Otherwise, only the other core alive: enter the corresponding hold state.
  - Both become alive in the same cycle: the current selection wins.
- Counter: 16 bits, cleared on every hold-state entry and exit, never wraps.
- switch_pulse is high only in the cycle where sel_b differs from its previous value.
- fault_a and fault_b lag alive_a and alive_b by one cycle.
- Reset asserted mid-hold: immediate return to S_A with sel_b = 0, with no switch_pulse.

Optional Feature:
- Macro: CORE_SWITCH_COUNT_EN.
- Defined:
  - Adds output switch_count [7:0], reset 0, incremented on every switch_pulse.
  - Saturates at 255.
  - Input clr_count (1 bit) clears it synchronously; clear takes priority over an increment in the same cycle.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Shared package/defines file holds:
  - The state encodings S_A..S_NONE and the 3-bit state width.
  - The default HOLD_CYCLES, derived from the existing OSC frequency macro.
- One sub-module is natural: core_switch_hold_timer, the 16-bit clear/enable counter with a terminal flag at HOLD_CYCLES-1. The FSM stays in the top.

Test Plan:
- Run with HOLD_CYCLES = 8.
- Release reset with alive_a = alive_b = 1 -> state = S_A, sel_b = 0, switch_pulse never asserted over 100 cycles.
- In S_A, drop alive_a at cycle t while alive_b = 1 -> sel_b = 1 and switch_pulse = 1 exactly at t+8, one cycle wide.
- In S_A, drop alive_a for 5 cycles, then restore it -> returns to S_A; sel_b stays 0 and switch_pulse stays 0.
- Drop both alive signals in S_B -> no_core = 1, sel_b stays 1.
  - Then raise only alive_a -> switch to A 8 cycles later.
  - Repeat, raising only alive_b -> immediate S_B with no pulse.
- With REVERTIVE = 1, in S_B with both alive -> sel_b returns to 0 after 8 cycles. With REVERTIVE = 0, the same stimulus keeps sel_b = 1 indefinitely.
- With CORE_SWITCH_COUNT_EN defined:
  - Force 300 switchovers -> switch_count = 255.
  - Then pulse clr_count -> 0 on the next cycle.
  - Assert rst mid-hold -> sel_b = 0, count = 0.

Source files
------------

// File: rtl/core_switch_pkg.sv
// Shared encodings and defaults for the core A/B switchover controller.
// Default holdoff is derived from OSC_FREQ_HZ (1 ms, rounded).
`ifndef OSC_FREQ_HZ
`define OSC_FREQ_HZ 14745600
`endif

package core_switch_pkg;

    localparam int STATE_W = 3;
    localparam int CNT_W   = 16;

    localparam logic [STATE_W-1:0] S_A      = 3'd0;
    localparam logic [STATE_W-1:0] S_B      = 3'd1;
    localparam logic [STATE_W-1:0] S_HOLD_B = 3'd2;
    localparam logic [STATE_W-1:0] S_HOLD_A = 3'd3;
    localparam logic [STATE_W-1:0] S_NONE   = 3'd4;

    localparam int HOLD_CYCLES_DEF = (`OSC_FREQ_HZ + 500) / 1000;

endpackage

// File: rtl/core_switch_hold_timer.sv
// 16-bit holdoff counter: synchronous clear, enable, saturating at all-ones,
// with a terminal flag once HOLD_CYCLES-1 cycles have been counted.
module core_switch_hold_timer
    import core_switch_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == LAST);

endmodule

// File: rtl/core_switch_ctrl.sv
// Core A/B active-selection FSM with qualified holdoff and optional revert.
// Define CORE_SWITCH_COUNT_EN to add the saturating switch_count/clr_count.
module core_switch_ctrl
    import core_switch_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter bit REVERTIVE   = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alive_a,
    input  logic               alive_b,
`ifdef CORE_SWITCH_COUNT_EN
    input  logic               clr_count,
    output logic [7:0]         switch_count,
`endif
    output logic               sel_b,
    output logic               switch_pulse,
    output logic               fault_a,
    output logic               fault_b,
    output logic               no_core,
    output logic [STATE_W-1:0] state
);

    logic [STATE_W-1:0] state_q, state_d;
    logic sel_b_q, sel_b_d;
    logic pulse_q, pulse_d;
    logic fault_a_q, fault_b_q;
    logic abort_b, abort_a;
    logic in_hold, tmr_en, tmr_clr, hold_done;

    // A revert hold was entered with B healthy, so only losing A cancels it.
    assign abort_b = alive_a || !alive_b;
    assign abort_a = REVERTIVE ? !alive_a : (alive_b || !alive_a);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_A: begin
                if (!alive_a) begin
                    state_d = alive_b ? S_HOLD_B : S_NONE;
                end
            end
            S_B: begin
                if (!alive_b) begin
                    state_d = alive_a ? S_HOLD_A : S_NONE;
                end else if (REVERTIVE && alive_a) begin
                    state_d = S_HOLD_A;
                end
            end
            S_HOLD_B: begin
                if (abort_b) begin
                    state_d = S_A;
                end else if (hold_done) begin
                    state_d = S_B;
                end
            end
            S_HOLD_A: begin
                if (abort_a) begin
                    state_d = S_B;
                end else if (hold_done) begin
                    state_d = S_A;
                end
            end
            S_NONE: begin
                if (sel_b_q ? alive_b : alive_a) begin
                    state_d = sel_b_q ? S_B : S_A;
                end else if (sel_b_q ? alive_a : alive_b) begin
                    state_d = sel_b_q ? S_HOLD_A : S_HOLD_B;
                end
            end
            default: state_d = S_A;
        endcase
    end

    // Counter runs only while remaining in a hold state; any move clears it.
    assign in_hold = (state_q == S_HOLD_A) || (state_q == S_HOLD_B);
    assign tmr_en  = in_hold && (state_d == state_q);
    assign tmr_clr = !tmr_en;

    core_switch_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .en  (tmr_en),
        .done(hold_done)
    );

    always_comb begin
        sel_b_d = sel_b_q;
        if (state_d == S_A) begin
            sel_b_d = 1'b0;
        end else if (state_d == S_B) begin
            sel_b_d = 1'b1;
        end
        pulse_d = sel_b_d ^ sel_b_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_A;
            sel_b_q   <= 1'b0;
            pulse_q   <= 1'b0;
            fault_a_q <= 1'b0;
            fault_b_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_b_q   <= sel_b_d;
            pulse_q   <= pulse_d;
            fault_a_q <= !alive_a;
            fault_b_q <= !alive_b;
        end
    end

`ifdef CORE_SWITCH_COUNT_EN
    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_count) begin
            count_d = '0;
        end else if (pulse_d && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign switch_count = count_q;
`endif

    assign sel_b        = sel_b_q;
    assign switch_pulse = pulse_q;
    assign fault_a      = fault_a_q;
    assign fault_b      = fault_b_q;
    assign no_core      = (state_q == S_NONE);
    assign state        = state_q;

endmodule

// File: tb/tb_core_switch_ctrl.sv
// Bench for core_switch_ctrl: non-revertive and revertive instances, HOLD=8,
// directed vector table, reset corners, random run against a behavioural model.
module tb_core_switch_ctrl;

    localparam int HOLD = 8;

    logic clk = 1'b0;
    logic rst, a, b, clr;
    logic sel0, p0, fa0, fb0, nc0;
    logic sel1, p1, fa1, fb1, nc1;
    logic [2:0] st0, st1;
`ifdef CORE_SWITCH_COUNT_EN
    logic [7:0] cnt0, cnt1;
`endif

    int checks = 0;
    int errors = 0;

    // Model: active core, "waiting to switch" with elapsed cycles, or no core.
    bit m_sel[2], m_wait[2], m_none[2], m_pulse[2];
    int m_w[2], m_cnt[2];
    bit m_fa, m_fb;

    always #5 clk = ~clk;

    core_switch_ctrl #(.HOLD_CYCLES(HOLD), .REVERTIVE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .alive_a(a), .alive_b(b),
`ifdef CORE_SWITCH_COUNT_EN
        .clr_count(clr), .switch_count(cnt0),
`endif
        .sel_b(sel0), .switch_pulse(p0), .fault_a(fa0), .fault_b(fb0),
        .no_core(nc0), .state(st0)
    );

    core_switch_ctrl #(.HOLD_CYCLES(HOLD), .REVERTIVE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .alive_a(a), .alive_b(b),
`ifdef CORE_SWITCH_COUNT_EN
        .clr_count(clr), .switch_count(cnt1),
`endif
        .sel_b(sel1), .switch_pulse(p1), .fault_a(fa1), .fault_b(fb1),
        .no_core(nc1), .state(st1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [2:0] m_state(input int i);
        if (m_none[i]) return 3'd4;
        if (m_wait[i]) return m_sel[i] ? 3'd3 : 3'd2;
        return m_sel[i] ? 3'd1 : 3'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_sel[i] = 0; m_wait[i] = 0; m_none[i] = 0;
            m_pulse[i] = 0; m_w[i] = 0; m_cnt[i] = 0;
        end
        m_fa = 0; m_fb = 0;
    endtask

    task automatic model_step(input bit av, input bit bv, input bit cl);
        bit rev, cur, oth, old, abrt;
        for (int i = 0; i < 2; i++) begin
            rev = (i == 1);
            cur = m_sel[i] ? bv : av;
            oth = m_sel[i] ? av : bv;
            old = m_sel[i];
            if (m_wait[i]) begin
                if (m_sel[i]) abrt = rev ? !av : (bv || !av);
                else abrt = av || !bv;
                if (abrt) begin
                    m_wait[i] = 0;
                end else if (m_w[i] == HOLD - 1) begin
                    m_sel[i] = !m_sel[i];
                    m_wait[i] = 0;
                end else begin
                    m_w[i]++;
                end
            end else if (m_none[i]) begin
                if (cur) begin
                    m_none[i] = 0;
                end else if (oth) begin
                    m_none[i] = 0; m_wait[i] = 1; m_w[i] = 0;
                end
            end else if (!cur) begin
                if (oth) begin
                    m_wait[i] = 1; m_w[i] = 0;
                end else begin
                    m_none[i] = 1;
                end
            end else if (m_sel[i] && rev && av) begin
                m_wait[i] = 1; m_w[i] = 0;
            end
            m_pulse[i] = (m_sel[i] != old);
            if (cl) m_cnt[i] = 0;
            else if (m_pulse[i] && m_cnt[i] < 255) m_cnt[i]++;
        end
        m_fa = !av;
        m_fb = !bv;
    endtask

    task automatic compare_all();
        chk("d0.sel_b", sel0, m_sel[0]);
        chk("d0.pulse", p0, m_pulse[0]);
        chk("d0.no_core", nc0, m_none[0]);
        chk("d0.state", st0, m_state(0));
        chk("d0.fault_a", fa0, m_fa);
        chk("d0.fault_b", fb0, m_fb);
        chk("d1.sel_b", sel1, m_sel[1]);
        chk("d1.pulse", p1, m_pulse[1]);
        chk("d1.no_core", nc1, m_none[1]);
        chk("d1.state", st1, m_state(1));
        chk("d1.fault_a", fa1, m_fa);
        chk("d1.fault_b", fb1, m_fb);
`ifdef CORE_SWITCH_COUNT_EN
        chk("d0.count", cnt0, m_cnt[0]);
        chk("d1.count", cnt1, m_cnt[1]);
`endif
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            model_step(a, b, clr);
            compare_all();
        end
    endtask

    // Asserted asynchronously between edges; outputs must clear immediately.
    task automatic apply_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst.sel_b", sel0, 1'b0);
        chk("rst.state", st0, 3'd0);
        chk("rst.pulse", p0, 1'b0);
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit a, b;
        int n;
        bit e_sel, e_pulse, e_nc;
        logic [2:0] e_st;
        bit e_sel_r;
        logic [2:0] e_st_r;
    } vec_t;

    vec_t tbl[14];
    bit saw_pulse;

    initial begin
        rst = 1'b1; a = 1'b1; b = 1'b1; clr = 1'b0;
        model_reset();

        //           a  b  n   sel pls nc st   sel_r st_r
        tbl[0]  = '{0, 1, 8,  0,  0,  0, 3'd2, 0, 3'd2};
        tbl[1]  = '{0, 1, 1,  1,  1,  0, 3'd1, 1, 3'd1};
        tbl[2]  = '{0, 1, 1,  1,  0,  0, 3'd1, 1, 3'd1};
        tbl[3]  = '{0, 0, 1,  1,  0,  1, 3'd4, 1, 3'd4};
        tbl[4]  = '{1, 0, 1,  1,  0,  0, 3'd3, 1, 3'd3};
        tbl[5]  = '{1, 0, 7,  1,  0,  0, 3'd3, 1, 3'd3};
        tbl[6]  = '{1, 0, 1,  0,  1,  0, 3'd0, 0, 3'd0};
        tbl[7]  = '{1, 0, 1,  0,  0,  0, 3'd0, 0, 3'd0};
        tbl[8]  = '{0, 1, 5,  0,  0,  0, 3'd2, 0, 3'd2};
        tbl[9]  = '{1, 1, 1,  0,  0,  0, 3'd0, 0, 3'd0};
        tbl[10] = '{0, 1, 9,  1,  1,  0, 3'd1, 1, 3'd1};
        tbl[11] = '{0, 0, 1,  1,  0,  1, 3'd4, 1, 3'd4};
        tbl[12] = '{0, 1, 1,  1,  0,  0, 3'd1, 1, 3'd1};
        tbl[13] = '{1, 1, 20, 1,  0,  0, 3'd1, 0, 3'd0};

        apply_reset();

        saw_pulse = 0;
        for (int k = 0; k < 100; k++) begin
            tick(1);
            if (p0 || p1) saw_pulse = 1;
        end
        chk("idle_no_pulse", saw_pulse, 1'b0);

        for (int i = 0; i < 14; i++) begin
            a = tbl[i].a;
            b = tbl[i].b;
            tick(tbl[i].n);
            chk($sformatf("vec%0d.sel", i), sel0, tbl[i].e_sel);
            chk($sformatf("vec%0d.pulse", i), p0, tbl[i].e_pulse);
            chk($sformatf("vec%0d.nc", i), nc0, tbl[i].e_nc);
            chk($sformatf("vec%0d.state", i), st0, tbl[i].e_st);
            chk($sformatf("vec%0d.sel_r", i), sel1, tbl[i].e_sel_r);
            chk($sformatf("vec%0d.state_r", i), st1, tbl[i].e_st_r);
        end

        // dut0 is in S_B: lose B so it holds toward A, then reset mid-hold.
        a = 1'b1; b = 1'b0;
        tick(3);
        chk("midhold.state", st0, 3'd3);
        #2;
        apply_reset();

        a = 1'b1; b = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                a = 1'($urandom);
                b = 1'($urandom);
            end
            clr = ($urandom_range(0, 99) == 0);
            tick(1);
        end
        clr = 1'b0;

`ifdef CORE_SWITCH_COUNT_EN
        #2;
        apply_reset();
        for (int k = 0; k < 150; k++) begin
            a = 1'b0; b = 1'b1;
            tick(10);
            a = 1'b1; b = 1'b0;
            tick(10);
        end
        chk("count_sat0", cnt0, 8'd255);
        chk("count_sat1", cnt1, 8'd255);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("count_clr", cnt0, 8'd0);
        a = 1'b0; b = 1'b1;
        tick(10);
        chk("count_one", cnt0, 8'd1);
        a = 1'b1; b = 1'b0;
        tick(3);
        #2;
        apply_reset();
        chk("rst_count", cnt0, 8'd0);
        chk("rst_count_sel", sel0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
